jtdsp16_prog_load: RTL and testbench
====================================

JTDSP16_PROG_LOAD -- requirements
Module: jtdsp16_prog_load

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4: number of cen cycles for which core_rst stays high after the download ends.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port cen, input, 1 bit: clock enable; all state advances only when cen=1.
REQ-005 SHALL have port prog_we, input, 1 bit: download strobe; high means a word is being written.
REQ-006 SHALL have port prog_addr, input, 12 bits: download word address.
REQ-007 SHALL have port prog_data, input, 16 bits: download word.
REQ-008 SHALL have port fetch_addr, input, 12 bits: core instruction fetch address.
REQ-009 SHALL have port fetch_data, output, 16 bits: fetched instruction, registered.
REQ-010 SHALL have port core_rst, output, 1 bit: holds the DSP core in reset.
REQ-011 SHALL have port load_done, output, 1 bit: a complete program is loaded and the core is running.
REQ-012 SHALL have port load_cnt, output, 13 bits: number of words written in the current download.

Function
REQ-013 SHALL contain a 4096x16 program RAM.
REQ-014 SHALL implement four states (IDLE, LOAD, SETTLE, RUN); IDLE is entered at reset.
REQ-015 IDLE: in a cen cycle with prog_we=1, the block SHALL go to LOAD and perform that cycle's write; with prog_we=0 it SHALL stay in IDLE.
REQ-016 In LOAD, each cen cycle with prog_we=1 SHALL write prog_data to ram[prog_addr] and increment load_cnt, saturating at 4096.
REQ-017 In LOAD, a cen cycle with prog_we=0 SHALL move the block to SETTLE and load the settle counter with SETTLE_CYC-1.
REQ-018 SETTLE: the counter SHALL decrement once per cen cycle; on reaching 0 the block SHALL go to RUN; prog_we=1 during SETTLE SHALL return it to LOAD with the write performed and load_cnt continuing.
REQ-019 In RUN, prog_we=1 SHALL restart the download: go to LOAD, set load_cnt to 1, and perform the write.
REQ-020 core_rst SHALL be a registered output equal to 1 in IDLE, LOAD and SETTLE, and 0 only in RUN.
REQ-021 load_done SHALL be a registered output equal to 1 only in RUN.
REQ-022 In RUN, fetch_data SHALL update to ram[fetch_addr] one cen cycle after fetch_addr is sampled; outside RUN it SHALL update to 0.
REQ-023 Duplicate download addresses SHALL overwrite earlier data (last write wins), and each such write SHALL still count in load_cnt.
REQ-024 When cen=0, all registers and outputs SHALL hold and the RAM SHALL NOT be written.

Reset
REQ-025 rst=1 SHALL set: state=IDLE, core_rst=1, load_done=0, load_cnt=0, fetch_data=0, settle counter=0.
REQ-026 rst SHALL take priority over cen and prog_we.
REQ-027 RAM contents SHALL NOT be cleared by rst.
REQ-028 A reset mid-download SHALL abort the download; a following prog_we restarts from load_cnt=0.

Configuration
REQ-029 With JTDSP16_PROG_CHKSUM_EN defined, the block SHALL add output chksum (16 bits): the modulo-2^16 sum of every prog_data word written in the current download.
REQ-030 chksum SHALL be cleared by rst and by a download restart from RUN, and SHALL update in the same cycle as load_cnt.
REQ-031 Without JTDSP16_PROG_CHKSUM_EN, the chksum port and its adder SHALL be absent.

Structure
REQ-032 A shared package jtdsp16_pkg SHALL hold the state enum, PROG_AW=12, PROG_DW=16 and the RAM depth constant 4096.
REQ-033 The RAM SHALL be a sub-module jtdsp16_prog_ram: one write port and one registered read port, with no reset.

Verification
REQ-034 Bench SHALL cover rst, then cen=1 with words 0..511 written as data=addr^16'hA5A5 -> load_cnt=512; core_rst=1 until SETTLE_CYC+1 cycles after prog_we falls, then core_rst=0 and load_done=1.
REQ-035 Bench SHALL cover a fetch in RUN at fetch_addr=12'h010 -> fetch_data=16'hA5B5 on the next cycle.
REQ-036 Bench SHALL cover cen toggling 1/0 during the download -> the RAM holds identical data and load_cnt=512, with no writes on cen=0 cycles.
REQ-037 Bench SHALL cover a second prog_we burst in RUN of 3 words (1,2,3) at address 0 -> core_rst=1 on the next cycle, load_cnt=3, ram[0]=3, and chksum=6 when the macro is defined.
REQ-038 Bench SHALL cover rst asserted after 100 download words -> IDLE, load_cnt=0, core_rst=1, and ram[0..99] retained.
REQ-039 Bench SHALL cover a prog_we gap of 1 cycle in SETTLE with SETTLE_CYC=4 -> return to LOAD, load_cnt continuing, and load_done never asserting.

Source files
------------

// File: rtl/jtdsp16_pkg.sv
// Shared types and constants for the JTDSP16 program download path.
// Optional chksum output is enabled by JTDSP16_PROG_CHKSUM_EN.
package jtdsp16_pkg;

    localparam int PROG_AW    = 12;
    localparam int PROG_DW    = 16;
    localparam int PROG_DEPTH = 4096;
    localparam int CNT_W      = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_RUN
    } load_state_t;

    // Word counter stops at the RAM depth instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_W'(PROG_DEPTH)) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/jtdsp16_prog_ram.sv
// 4096x16 program RAM: one write port, one registered read port.
// No reset, so contents survive a block reset.
module jtdsp16_prog_ram
    import jtdsp16_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [PROG_AW-1:0] wr_addr,
    input  logic [PROG_DW-1:0] wr_data,
    input  logic               rd_en,
    input  logic [PROG_AW-1:0] rd_addr,
    output logic [PROG_DW-1:0] rd_data
);

    logic [PROG_DW-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jtdsp16_prog_load.sv
// Program download controller: loads the DSP16 program RAM and holds the core
// in reset until the download has settled. JTDSP16_PROG_CHKSUM_EN adds chksum.
module jtdsp16_prog_load
    import jtdsp16_pkg::*;
#(
    parameter int SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               prog_we,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [PROG_DW-1:0] prog_data,
    input  logic [PROG_AW-1:0] fetch_addr,
    output logic [PROG_DW-1:0] fetch_data,
    output logic               core_rst,
    output logic               load_done,
    output logic [CNT_W-1:0]   load_cnt
`ifdef JTDSP16_PROG_CHKSUM_EN
   ,output logic [PROG_DW-1:0] chksum
`endif
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    load_state_t        st, st_nx;
    logic [SW-1:0]      scnt, scnt_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic               restart;
    logic               fetch_ok;
    logic               ram_we;
    logic [PROG_DW-1:0] rd_q;

    always_comb begin
        st_nx   = st;
        scnt_nx = scnt;
        cnt_nx  = load_cnt;
        restart = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (prog_we) begin
                    st_nx  = ST_LOAD;
                    cnt_nx = cnt_inc(load_cnt);
                end
            end
            ST_LOAD: begin
                if (prog_we) begin
                    cnt_nx = cnt_inc(load_cnt);
                end else begin
                    st_nx   = ST_SETTLE;
                    scnt_nx = SW'(SETTLE_CYC - 1);
                end
            end
            ST_SETTLE: begin
                if (prog_we) begin
                    st_nx  = ST_LOAD;
                    cnt_nx = cnt_inc(load_cnt);
                end else if (scnt == '0) begin
                    st_nx = ST_RUN;
                end else begin
                    scnt_nx = scnt - SW'(1);
                end
            end
            ST_RUN: begin
                if (prog_we) begin
                    st_nx   = ST_LOAD;
                    cnt_nx  = CNT_W'(1);
                    restart = 1'b1;
                end
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with st.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            scnt      <= '0;
            load_cnt  <= '0;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            fetch_ok  <= 1'b0;
        end else if (cen) begin
            st        <= st_nx;
            scnt      <= scnt_nx;
            load_cnt  <= cnt_nx;
            core_rst  <= (st_nx != ST_RUN);
            load_done <= (st_nx == ST_RUN);
            fetch_ok  <= (st == ST_RUN);
        end
    end

`ifdef JTDSP16_PROG_CHKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            chksum <= '0;
        end else if (cen) begin
            if (restart) chksum <= prog_data;
            else if (prog_we) chksum <= chksum + prog_data;
        end
    end
`else
    logic unused_restart;
    assign unused_restart = restart;
`endif

    assign ram_we = cen & prog_we & ~rst;

    jtdsp16_prog_ram u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_en   (cen),
        .rd_addr (fetch_addr),
        .rd_data (rd_q)
    );

    // The RAM read register has no reset; mask it until a RUN-cycle fetch.
    assign fetch_data = fetch_ok ? rd_q : '0;

endmodule

// File: tb/tb_jtdsp16_prog_load.sv
// Directed bench for jtdsp16_prog_load: table vectors plus download sequences.
// Chksum checks are compiled in with JTDSP16_PROG_CHKSUM_EN.
module tb_jtdsp16_prog_load;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic        prog_we = 1'b0;
    logic [11:0] prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [11:0] fetch_addr = '0;
    logic [15:0] fetch_data;
    logic        core_rst;
    logic        load_done;
    logic [12:0] load_cnt;
`ifdef JTDSP16_PROG_CHKSUM_EN
    logic [15:0] chksum;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jtdsp16_prog_load #(.SETTLE_CYC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .core_rst   (core_rst),
        .load_done  (load_done),
        .load_cnt   (load_cnt)
`ifdef JTDSP16_PROG_CHKSUM_EN
       ,.chksum     (chksum)
`endif
    );

    typedef struct {
        logic        cen;
        logic        we;
        logic [11:0] addr;
        logic [15:0] data;
        logic [12:0] cnt;
        logic        crst;
        logic        done;
        logic [15:0] chk;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
    endtask

    task automatic fetch_chk(input string name, input logic [11:0] a, input logic [15:0] exp);
        prog_we    = 1'b0;
        fetch_addr = a;
        tick();
        check(name, {16'h0, fetch_data}, {16'h0, exp});
    endtask

    task automatic settle_chk(input string name);
        prog_we = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k < 5) begin
                check({name, " crst"}, {31'h0, core_rst}, 32'h1);
                check({name, " done"}, {31'h0, load_done}, 32'h0);
            end
        end
        check({name, " run crst"}, {31'h0, core_rst}, 32'h0);
        check({name, " run done"}, {31'h0, load_done}, 32'h1);
    endtask

    logic [15:0] acc;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 12'd0,   16'd1, 13'd1, 1'b1, 1'b0, 16'd1};
        tbl[1]  = '{1'b1, 1'b1, 12'd0,   16'd2, 13'd2, 1'b1, 1'b0, 16'd3};
        tbl[2]  = '{1'b1, 1'b1, 12'd0,   16'd3, 13'd3, 1'b1, 1'b0, 16'd6};
        tbl[3]  = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd6};
        tbl[4]  = '{1'b0, 1'b1, 12'd5,   16'd9, 13'd3, 1'b1, 1'b0, 16'd6};
        tbl[5]  = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd6};
        tbl[6]  = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd6};
        tbl[7]  = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd6};
        tbl[8]  = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b0, 1'b1, 16'd6};
        tbl[9]  = '{1'b1, 1'b1, 12'd100, 16'd7, 13'd1, 1'b1, 1'b0, 16'd7};
        tbl[10] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd1, 1'b1, 1'b0, 16'd7};
        tbl[11] = '{1'b1, 1'b1, 12'd101, 16'd8, 13'd2, 1'b1, 1'b0, 16'd15};
        tbl[12] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd2, 1'b1, 1'b0, 16'd15};
        tbl[13] = '{1'b1, 1'b1, 12'd102, 16'd9, 13'd3, 1'b1, 1'b0, 16'd24};
        tbl[14] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd24};
        tbl[15] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd24};
        tbl[16] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd24};
        tbl[17] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b1, 1'b0, 16'd24};
        tbl[18] = '{1'b1, 1'b0, 12'd0,   16'd0, 13'd3, 1'b0, 1'b1, 16'd24};

        // Reset state, with prog_we high to show rst wins.
        prog_we = 1'b1;
        repeat (3) tick();
        check("rst crst", {31'h0, core_rst}, 32'h1);
        check("rst done", {31'h0, load_done}, 32'h0);
        check("rst cnt", {19'h0, load_cnt}, 32'h0);
        check("rst fetch", {16'h0, fetch_data}, 32'h0);
`ifdef JTDSP16_PROG_CHKSUM_EN
        check("rst chksum", {16'h0, chksum}, 32'h0);
`endif
        rst = 1'b0;
        prog_we = 1'b0;
        tick();
        check("idle cnt", {19'h0, load_cnt}, 32'h0);

        // 512-word download and settle timing.
        acc = '0;
        for (int i = 0; i < 512; i++) begin
            wr(12'(i), 16'(i) ^ 16'hA5A5);
            acc = acc + (16'(i) ^ 16'hA5A5);
        end
        check("dl cnt", {19'h0, load_cnt}, 32'd512);
        check("dl crst", {31'h0, core_rst}, 32'h1);
`ifdef JTDSP16_PROG_CHKSUM_EN
        check("dl chksum", {16'h0, chksum}, {16'h0, acc});
`endif
        settle_chk("dl settle");
        fetch_chk("fetch 010", 12'h010, 16'hA5B5);
        fetch_chk("fetch 1ff", 12'h1FF, 16'hA45A);

        // Restart burst from RUN, then SETTLE gaps.
        for (int i = 0; i < 19; i++) begin
            cen       = tbl[i].cen;
            prog_we   = tbl[i].we;
            prog_addr = tbl[i].addr;
            prog_data = tbl[i].data;
            tick();
            check($sformatf("vec%0d cnt", i), {19'h0, load_cnt}, {19'h0, tbl[i].cnt});
            check($sformatf("vec%0d crst", i), {31'h0, core_rst}, {31'h0, tbl[i].crst});
            check($sformatf("vec%0d done", i), {31'h0, load_done}, {31'h0, tbl[i].done});
`ifdef JTDSP16_PROG_CHKSUM_EN
            check($sformatf("vec%0d chk", i), {16'h0, chksum}, {16'h0, tbl[i].chk});
`endif
            if (i == 8) begin
                fetch_chk("ram0 last wins", 12'h000, 16'h0003);
                fetch_chk("ram5 no cen write", 12'h005, 16'hA5A0);
            end
        end
        cen = 1'b1;
        fetch_chk("ram100", 12'd100, 16'd7);
        fetch_chk("ram102", 12'd102, 16'd9);

        // Reset in the middle of a 100-word download.
        for (int i = 0; i < 100; i++) wr(12'(i), 16'(i) ^ 16'h1234);
        check("mid cnt", {19'h0, load_cnt}, 32'd100);
        rst = 1'b1;
        prog_addr = 12'h000;
        prog_data = 16'hFFFF;
        tick();
        check("mid rst cnt", {19'h0, load_cnt}, 32'h0);
        check("mid rst crst", {31'h0, core_rst}, 32'h1);
        check("mid rst done", {31'h0, load_done}, 32'h0);
        check("mid rst fetch", {16'h0, fetch_data}, 32'h0);
        rst = 1'b0;
        wr(12'd4000, 16'h0000);
        check("post rst cnt", {19'h0, load_cnt}, 32'h1);
        settle_chk("post rst settle");
        for (int i = 0; i < 100; i++)
            fetch_chk($sformatf("keep%0d", i), 12'(i), 16'(i) ^ 16'h1234);

        // Download with cen toggling; cen=0 cycles carry a bad word.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 512; i++) begin
            cen = 1'b1;
            wr(12'(i), 16'(i) ^ 16'h3C3C);
            cen = 1'b0;
            wr(12'(i), 16'hDEAD);
        end
        check("cen cnt", {19'h0, load_cnt}, 32'd512);
        prog_we = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cen = 1'b1;
            tick();
            cen = 1'b0;
            tick();
            if (k == 4) check("cen settle done", {31'h0, load_done}, 32'h0);
        end
        check("cen run done", {31'h0, load_done}, 32'h1);
        cen = 1'b1;
        fetch_chk("cen ram000", 12'h000, 16'h3C3C);
        fetch_chk("cen ram0ab", 12'h0AB, 16'h3C97);
        fetch_chk("cen ram1ff", 12'h1FF, 16'h3DC3);
        fetch_chk("cen ram010", 12'h010, 16'h3C2C);
        cen = 1'b0;
        fetch_addr = 12'h020;
        tick();
        check("cen fetch hold", {16'h0, fetch_data}, 32'h3C2C);
        check("cen hold done", {31'h0, load_done}, 32'h1);
        cen = 1'b1;

        // load_cnt saturation at 4096.
        for (int i = 0; i < 4096; i++) wr(12'(i), 16'h0001);
        check("sat cnt 4096", {19'h0, load_cnt}, 32'd4096);
        wr(12'h000, 16'h0001);
        check("sat cnt hold", {19'h0, load_cnt}, 32'd4096);
`ifdef JTDSP16_PROG_CHKSUM_EN
        check("sat chksum", {16'h0, chksum}, 32'd4097);
`endif
        check("sat crst", {31'h0, core_rst}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
